// File: rtl/tlul_main_memory_arbiter.sv
// N-host TL-UL arbiter in front of the single main-memory TL-UL port.
// The A channel is granted round-robin and locked to a host while its request stalls.
// A host-index FIFO records the issuer of each accepted request, so the
// in-order D responses are routed back to the right host.

// Per-host response/ready steering: a host sees a_ready only while it is the
// granted host, and d_* only while it owns the FIFO head.
module tlul_arb_host_port #(
  parameter int SrcW = 8,
  parameter int DW   = 32
) (
  input  logic            sel_hit,
  input  logic            head_hit,
  input  logic            a_ready_en,
  input  logic            d_valid_en,
  input  logic [2:0]      rsp_opcode,
  input  logic [1:0]      rsp_size,
  input  logic [SrcW-1:0] rsp_source,
  input  logic [DW-1:0]   rsp_data,
  input  logic            rsp_error,
  output logic            a_ready,
  output logic            d_valid,
  output logic [2:0]      d_opcode,
  output logic [1:0]      d_size,
  output logic [SrcW-1:0] d_source,
  output logic [DW-1:0]   d_data,
  output logic            d_error
);
  assign a_ready  = sel_hit & a_ready_en;
  assign d_valid  = head_hit & d_valid_en;
  assign d_opcode = head_hit ? rsp_opcode : '0;
  assign d_size   = head_hit ? rsp_size   : '0;
  assign d_source = head_hit ? rsp_source : '0;
  assign d_data   = head_hit ? rsp_data   : '0;
  assign d_error  = head_hit & rsp_error;
endmodule

module tlul_main_memory_arbiter #(
  parameter  int NumHosts       = 4,
  parameter  int MaxOutstanding = 8,
  localparam int HostIdxW       = (NumHosts > 1) ? $clog2(NumHosts) : 1,
  localparam int CntW           = $clog2(MaxOutstanding + 1),
  localparam int AW             = 32,
  localparam int DW             = 32,
  localparam int SrcW           = 8,
  localparam int UserW          = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  // host-side requests
  input  logic [NumHosts-1:0]                tl_h_a_valid_i,
  input  logic [NumHosts-1:0][2:0]           tl_h_a_opcode_i,
  input  logic [NumHosts-1:0][1:0]           tl_h_a_size_i,
  input  logic [NumHosts-1:0][SrcW-1:0]      tl_h_a_source_i,
  input  logic [NumHosts-1:0][AW-1:0]        tl_h_a_address_i,
  input  logic [NumHosts-1:0][DW/8-1:0]      tl_h_a_mask_i,
  input  logic [NumHosts-1:0][DW-1:0]        tl_h_a_data_i,
  input  logic [NumHosts-1:0][UserW-1:0]     tl_h_a_user_i,
  input  logic [NumHosts-1:0]                tl_h_d_ready_i,
  // host-side responses
  output logic [NumHosts-1:0]                tl_h_a_ready_o,
  output logic [NumHosts-1:0]                tl_h_d_valid_o,
  output logic [NumHosts-1:0][2:0]           tl_h_d_opcode_o,
  output logic [NumHosts-1:0][1:0]           tl_h_d_size_o,
  output logic [NumHosts-1:0][SrcW-1:0]      tl_h_d_source_o,
  output logic [NumHosts-1:0][DW-1:0]        tl_h_d_data_o,
  output logic [NumHosts-1:0]                tl_h_d_error_o,
  // memory-side request
  output logic                               tl_d_a_valid_o,
  output logic [2:0]                         tl_d_a_opcode_o,
  output logic [1:0]                         tl_d_a_size_o,
  output logic [SrcW-1:0]                    tl_d_a_source_o,
  output logic [AW-1:0]                      tl_d_a_address_o,
  output logic [DW/8-1:0]                    tl_d_a_mask_o,
  output logic [DW-1:0]                      tl_d_a_data_o,
  output logic [UserW-1:0]                   tl_d_a_user_o,
  output logic                               tl_d_d_ready_o,
  // memory-side response
  input  logic                               tl_d_a_ready_i,
  input  logic                               tl_d_d_valid_i,
  input  logic [2:0]                         tl_d_d_opcode_i,
  input  logic [1:0]                         tl_d_d_size_i,
  input  logic [SrcW-1:0]                    tl_d_d_source_i,
  input  logic [DW-1:0]                      tl_d_d_data_i,
  input  logic                               tl_d_d_error_i,
  // status
  output logic [CntW-1:0]                    outstanding_o,
  output logic                               spurious_rsp_o
);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [HostIdxW-1:0] rr_ptr, lock_idx_q, sel, rr_next, head;
  logic                lock_q, req_vld;
  logic [HostIdxW-1:0] fifo_mem [MaxOutstanding];
  logic [PtrW-1:0]     wptr, rptr;
  logic [CntW-1:0]     count;
  logic                fifo_full, fifo_empty;
  logic                a_grant, push, pop, drop;
  logic                spurious_q;

  assign fifo_full  = (count == CntW'(MaxOutstanding));
  assign fifo_empty = (count == '0);

  // Pick the granted host: the locked one, else first requester from rr_ptr onward.
  always_comb begin : p_sel
    int j;
    sel     = rr_ptr;
    req_vld = 1'b0;
    j       = 0;
    if (lock_q) begin
      sel     = lock_idx_q;
      req_vld = tl_h_a_valid_i[lock_idx_q];
    end else begin
      // Walk the ring backwards so the lowest offset from rr_ptr wins last.
      for (int i = NumHosts - 1; i >= 0; i--) begin
        j = int'(rr_ptr) + i;
        if (j >= NumHosts) j = j - NumHosts;
        if (tl_h_a_valid_i[j]) begin
          sel     = HostIdxW'(j);
          req_vld = 1'b1;
        end
      end
    end
  end

  // Next round-robin start is the host after the one just granted.
  always_comb begin
    rr_next = '0;
    if (int'(sel) != NumHosts - 1) rr_next = sel + HostIdxW'(1);
  end

  // A channel: combinational mux of the granted host, blocked while the FIFO is full.
  assign tl_d_a_valid_o   = req_vld & ~fifo_full;
  assign tl_d_a_opcode_o  = tl_h_a_opcode_i[sel];
  assign tl_d_a_size_o    = tl_h_a_size_i[sel];
  assign tl_d_a_source_o  = tl_h_a_source_i[sel];
  assign tl_d_a_address_o = tl_h_a_address_i[sel];
  assign tl_d_a_mask_o    = tl_h_a_mask_i[sel];
  assign tl_d_a_data_o    = tl_h_a_data_i[sel];
  assign tl_d_a_user_o    = tl_h_a_user_i[sel];

  assign a_grant = tl_d_a_valid_o & tl_d_a_ready_i;
  assign push    = a_grant;

  // D channel: the FIFO head owns the response; with nothing in flight,
  // responses are accepted and thrown away.
  assign head           = fifo_mem[rptr];
  assign tl_d_d_ready_o = fifo_empty ? tl_d_d_valid_i : tl_h_d_ready_i[head];
  assign pop            = ~fifo_empty & tl_d_d_valid_i & tl_h_d_ready_i[head];
  assign drop           = fifo_empty & tl_d_d_valid_i;

  // Per-host steering of a_ready and the response fields.
  for (genvar g = 0; g < NumHosts; g++) begin : g_host
    tlul_arb_host_port #(.SrcW(SrcW), .DW(DW)) u_port (
      .sel_hit    (sel == HostIdxW'(g)),
      .head_hit   (~fifo_empty & (head == HostIdxW'(g))),
      .a_ready_en (req_vld & tl_d_a_ready_i & ~fifo_full),
      .d_valid_en (tl_d_d_valid_i),
      .rsp_opcode (tl_d_d_opcode_i),
      .rsp_size   (tl_d_d_size_i),
      .rsp_source (tl_d_d_source_i),
      .rsp_data   (tl_d_d_data_i),
      .rsp_error  (tl_d_d_error_i),
      .a_ready    (tl_h_a_ready_o[g]),
      .d_valid    (tl_h_d_valid_o[g]),
      .d_opcode   (tl_h_d_opcode_o[g]),
      .d_size     (tl_h_d_size_o[g]),
      .d_source   (tl_h_d_source_o[g]),
      .d_data     (tl_h_d_data_o[g]),
      .d_error    (tl_h_d_error_o[g])
    );
  end

  // Arbitration state: advance rr_ptr and unlock on accept, lock a stalled grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (a_grant) begin
      rr_ptr     <= rr_next;
      lock_q     <= 1'b0;
    end else if (tl_d_a_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  // Routing FIFO storage; contents are meaningless while count says empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr] <= sel;
  end

  // Routing FIFO pointers and occupancy; count is separate so any depth works.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == PtrW'(MaxOutstanding - 1)) ? '0 : wptr + PtrW'(1);
      if (pop)  rptr <= (rptr == PtrW'(MaxOutstanding - 1)) ? '0 : rptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a response that arrived with nothing in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   spurious_q <= 1'b0;
    else if (drop) spurious_q <= 1'b1;
  end

  assign outstanding_o  = count;
  assign spurious_rsp_o = spurious_q;
endmodule

// File: tb/tb_tlul_main_memory_arbiter.sv
// Directed bench for tlul_main_memory_arbiter (4 hosts, 8 outstanding).
module tb_tlul_main_memory_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        h_a_valid, h_d_ready, h_a_ready, h_d_valid, h_d_error;
  logic [3:0][2:0]   h_a_opcode, h_d_opcode;
  logic [3:0][1:0]   h_a_size, h_d_size;
  logic [3:0][7:0]   h_a_source, h_d_source;
  logic [3:0][31:0]  h_a_address, h_a_data, h_d_data;
  logic [3:0][3:0]   h_a_mask;
  logic [3:0][15:0]  h_a_user;
  logic              d_a_valid, d_d_ready, d_a_ready, d_d_valid, d_d_error;
  logic [2:0]        d_a_opcode, d_d_opcode;
  logic [1:0]        d_a_size, d_d_size;
  logic [7:0]        d_a_source, d_d_source;
  logic [31:0]       d_a_address, d_a_data, d_d_data;
  logic [3:0]        d_a_mask;
  logic [15:0]       d_a_user;
  logic [3:0]        outstanding;
  logic              spurious;

  tlul_main_memory_arbiter #(.NumHosts(4), .MaxOutstanding(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tl_h_a_valid_i(h_a_valid), .tl_h_a_opcode_i(h_a_opcode), .tl_h_a_size_i(h_a_size),
    .tl_h_a_source_i(h_a_source), .tl_h_a_address_i(h_a_address), .tl_h_a_mask_i(h_a_mask),
    .tl_h_a_data_i(h_a_data), .tl_h_a_user_i(h_a_user), .tl_h_d_ready_i(h_d_ready),
    .tl_h_a_ready_o(h_a_ready), .tl_h_d_valid_o(h_d_valid), .tl_h_d_opcode_o(h_d_opcode),
    .tl_h_d_size_o(h_d_size), .tl_h_d_source_o(h_d_source), .tl_h_d_data_o(h_d_data),
    .tl_h_d_error_o(h_d_error),
    .tl_d_a_valid_o(d_a_valid), .tl_d_a_opcode_o(d_a_opcode), .tl_d_a_size_o(d_a_size),
    .tl_d_a_source_o(d_a_source), .tl_d_a_address_o(d_a_address), .tl_d_a_mask_o(d_a_mask),
    .tl_d_a_data_o(d_a_data), .tl_d_a_user_o(d_a_user), .tl_d_d_ready_o(d_d_ready),
    .tl_d_a_ready_i(d_a_ready), .tl_d_d_valid_i(d_d_valid), .tl_d_d_opcode_i(d_d_opcode),
    .tl_d_d_size_i(d_d_size), .tl_d_d_source_i(d_d_source), .tl_d_d_data_i(d_d_data),
    .tl_d_d_error_i(d_d_error),
    .outstanding_o(outstanding), .spurious_rsp_o(spurious)
  );

  typedef struct {
    logic       rst;
    logic [3:0] a_vld;
    logic       a_rdy;
    logic       d_vld;
    logic [3:0] d_rdy;
    logic       e_avld;
    logic [7:0] e_src;
    logic [3:0] e_ardy;
    logic [3:0] e_dvld;
    logic       e_drdy;
    logic [3:0] e_out;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic rst, logic [3:0] a_vld, logic a_rdy, logic d_vld,
                              logic [3:0] d_rdy, logic e_avld, logic [7:0] e_src,
                              logic [3:0] e_ardy, logic [3:0] e_dvld, logic e_drdy,
                              logic [3:0] e_out);
    vec_t v;
    v.rst = rst; v.a_vld = a_vld; v.a_rdy = a_rdy; v.d_vld = d_vld; v.d_rdy = d_rdy;
    v.e_avld = e_avld; v.e_src = e_src; v.e_ardy = e_ardy; v.e_dvld = e_dvld;
    v.e_drdy = e_drdy; v.e_out = e_out;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a_vld, input logic a_rdy, input logic d_vld,
                       input logic [3:0] d_rdy);
    h_a_valid = a_vld;
    d_a_ready = a_rdy;
    d_d_valid = d_vld;
    h_d_ready = d_rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_spurious", 32'(spurious), 0);
    chk("rst_h_a_ready", 32'(h_a_ready), 0);
    chk("rst_h_d_valid", 32'(h_d_valid), 0);
    chk("rst_d_a_valid", 32'(d_a_valid), 0);
    chk("rst_d_d_ready", 32'(d_d_ready), 0);
    rst_n = 1'b1;
  endtask

  // Watchdog so a broken design can never stall the run.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      h_a_opcode[i]  = 3'd4;
      h_a_size[i]    = 2'd2;
      h_a_source[i]  = 8'h10 + 8'(i);
      h_a_address[i] = 32'h1000 + 32'(i) * 32'h100;
      h_a_mask[i]    = 4'hF;
      h_a_data[i]    = 32'hA000_0000 + 32'(i);
      h_a_user[i]    = 16'h0100 + 16'(i);
    end
    d_d_opcode = 3'd1; d_d_size = 2'd2; d_d_source = 8'h10;
    d_d_data = 32'hD00D_0003; d_d_error = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 4'h0);

    // Contention 0,1,2,3,0,1, one push/pop overlap, then in-order routing.
    vecs.push_back(mk(1, 4'hF, 1, 0, 4'hF, 1, 8'h10, 4'h1, 4'h0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 1, 0, 4'hF, 1, 8'h11, 4'h2, 4'h0, 1, 1));
    vecs.push_back(mk(0, 4'hF, 1, 0, 4'hF, 1, 8'h12, 4'h4, 4'h0, 1, 2));
    vecs.push_back(mk(0, 4'hF, 1, 0, 4'hF, 1, 8'h13, 4'h8, 4'h0, 1, 3));
    vecs.push_back(mk(0, 4'hF, 1, 0, 4'hF, 1, 8'h10, 4'h1, 4'h0, 1, 4));
    vecs.push_back(mk(0, 4'hF, 1, 0, 4'hF, 1, 8'h11, 4'h2, 4'h0, 1, 5));
    vecs.push_back(mk(0, 4'h4, 1, 1, 4'hF, 1, 8'h12, 4'h4, 4'h1, 1, 6));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h2, 1, 6));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h4, 1, 5));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h8, 1, 4));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h1, 1, 3));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h2, 1, 2));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h4, 1, 1));
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'hF, 0, 8'h00, 4'h0, 4'h0, 0, 0));
    // Backpressure: head host1 holds d_ready low for 4 cycles.
    vecs.push_back(mk(1, 4'h2, 1, 0, 4'hF, 1, 8'h11, 4'h2, 4'h0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 4'h0, 1, 1, 4'hD, 0, 8'h00, 4'h0, 4'h2, 0, 1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 4'hF, 0, 8'h00, 4'h0, 4'h2, 1, 1));
    vecs.push_back(mk(0, 4'h0, 1, 0, 4'hF, 0, 8'h00, 4'h0, 4'h0, 0, 0));

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      @(negedge clk);
      drive(vecs[k].a_vld, vecs[k].a_rdy, vecs[k].d_vld, vecs[k].d_rdy);
      #1;
      chk($sformatf("v%0d_d_a_valid", k), 32'(d_a_valid), 32'(vecs[k].e_avld));
      if (vecs[k].e_avld)
        chk($sformatf("v%0d_d_a_source", k), 32'(d_a_source), 32'(vecs[k].e_src));
      chk($sformatf("v%0d_h_a_ready", k), 32'(h_a_ready), 32'(vecs[k].e_ardy));
      chk($sformatf("v%0d_h_d_valid", k), 32'(h_d_valid), 32'(vecs[k].e_dvld));
      chk($sformatf("v%0d_d_d_ready", k), 32'(d_d_ready), 32'(vecs[k].e_drdy));
      chk($sformatf("v%0d_outstanding", k), 32'(outstanding), 32'(vecs[k].e_out));
    end

    // Idle single host Get, response 3 cycles after accept.
    do_reset();
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive((c == 0) ? 4'h1 : 4'h0, 1'b1, (c == 3), 4'hF);
      #1;
      if (h_d_valid[0]) n++;
      if (c == 0) begin
        chk("get_address", d_a_address, 32'h1000);
        chk("get_opcode", 32'(d_a_opcode), 4);
        chk("get_user", 32'(d_a_user), 32'h100);
        chk("get_a_ready", 32'(h_a_ready), 1);
        chk("get_out0", 32'(outstanding), 0);
      end
      if (c == 1) chk("get_out1", 32'(outstanding), 1);
      if (c == 3) begin
        chk("get_d_data", h_d_data[0], 32'hD00D_0003);
        chk("get_d_ready", 32'(d_d_ready), 1);
      end
      if (c == 4) chk("get_out_end", 32'(outstanding), 0);
    end
    chk("get_dvalid_count", 32'(n), 1);

    // Lock: host2 stalls 5 cycles, host0 joins at cycle 2 and must wait.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 6) drive((c >= 2) ? 4'h5 : 4'h4, (c == 5), 1'b0, 4'hF);
      else       drive(4'h1, 1'b1, 1'b0, 4'hF);
      #1;
      chk($sformatf("lock_c%0d_valid", c), 32'(d_a_valid), 1);
      chk($sformatf("lock_c%0d_src", c), 32'(d_a_source), (c < 6) ? 32'h12 : 32'h10);
      chk($sformatf("lock_c%0d_a_ready", c), 32'(h_a_ready),
          (c < 5) ? 32'h0 : ((c == 5) ? 32'h4 : 32'h1));
    end

    // Outstanding limit: 10 attempts, memory silent until full.
    do_reset();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(4'h1, 1'b1, 1'b0, 4'hF);
      #1;
      if (h_a_ready[0]) n++;
    end
    chk("lim_accepted", 32'(n), 8);
    chk("lim_outstanding", 32'(outstanding), 8);
    chk("lim_d_a_valid", 32'(d_a_valid), 0);
    @(negedge clk);
    drive(4'h1, 1'b1, 1'b1, 4'hF);
    #1;
    chk("lim_pop_a_ready", 32'(h_a_ready), 0);
    chk("lim_pop_d_valid", 32'(h_d_valid), 1);
    @(negedge clk);
    drive(4'h1, 1'b1, 1'b0, 4'hF);
    #1;
    chk("lim_after_out", 32'(outstanding), 7);
    chk("lim_after_a_ready", 32'(h_a_ready), 1);

    // Spurious response with nothing in flight.
    do_reset();
    @(negedge clk);
    drive(4'h0, 1'b0, 1'b1, 4'h0);
    #1;
    chk("spur_d_ready", 32'(d_d_ready), 1);
    chk("spur_h_d_valid", 32'(h_d_valid), 0);
    chk("spur_flag_pre", 32'(spurious), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(4'h0, 1'b0, 1'b0, 4'h0);
      #1;
      chk($sformatf("spur_flag_c%0d", c), 32'(spurious), 1);
      chk($sformatf("spur_out_c%0d", c), 32'(outstanding), 0);
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
